// File: rtl/lcd_num_fmt.sv
// Binary-to-ASCII formatter feeding the character LCD driver (double-dabble + leading-zero blanking).
// Latency: WIDTH+1 cycles from accepted start to done; read port has 1 cycle latency.
// Backpressure: none; start is only honoured in IDLE, and pulses while busy are dropped.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   start, value      conversion request and the unsigned binary value to convert
//   busy, done        conversion in progress / one-cycle pulse when the new string is committed
//   char_idx, char_out registered character read port (index 0 = most significant digit)
module lcd_num_fmt #(
   parameter int WIDTH  = 16,
   parameter int DIGITS = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] value,
   output logic             busy,
   output logic             done,
   input  logic [2:0]       char_idx,
   output logic [7:0]       char_out
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam int BW = 4 * DIGITS;
   localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      CONV,
      COMMIT
   } state_t;

   state_t state, state_nxt;

   logic [WIDTH-1:0] bin_q;
   logic [BW-1:0]    bcd_q;
   logic [CW-1:0]    cnt_q;
   logic [7:0]       buf_q [DIGITS];

   logic [BW-1:0]       bcd_adj;
   logic [BW+WIDTH-1:0] shifted;
   logic [7:0]          ascii [DIGITS];
   logic                seen;

   // ---------------------------------------------------------------
   // FSM
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b1;
      done      = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) state_nxt = CONV;
         end
         CONV: begin
            if (cnt_q == LAST_ITER) state_nxt = COMMIT;
         end
         COMMIT: begin
            // A reset landing on the commit cycle suppresses the pulse.
            done      = ~rst;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------------------------------------------------------
   // Double-dabble step: add 3 to every nibble >= 5 (4-bit wrap, no
   // inter-nibble carry), then shift {bcd, bin} left by one.
   // ---------------------------------------------------------------
   always_comb begin
      bcd_adj = bcd_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
      shifted = {bcd_adj, bin_q} << 1;
   end

   // ---------------------------------------------------------------
   // ASCII with leading-zero blanking. Scan from the most significant
   // nibble; once a nonzero digit (or the last digit) is seen, every
   // following digit is printed, so internal zeros stay visible.
   // ---------------------------------------------------------------
   always_comb begin
      seen = 1'b0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         ascii[DIGITS-1-i] = 8'h20;
         if (seen || (i == 0) || (bcd_q[4*i +: 4] != 4'd0)) begin
            seen              = 1'b1;
            ascii[DIGITS-1-i] = {4'h3, bcd_q[4*i +: 4]};
         end
      end
   end

   // ---------------------------------------------------------------
   // Datapath and display buffer. The buffer only changes in COMMIT so
   // the LCD driver never sees a half-updated string.
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         bin_q <= '0;
         bcd_q <= '0;
         cnt_q <= '0;
         for (int i = 0; i < DIGITS; i++) buf_q[i] <= 8'h20;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  bin_q <= value;
                  bcd_q <= '0;
                  cnt_q <= '0;
               end
            end
            CONV: begin
               bcd_q <= shifted[BW+WIDTH-1:WIDTH];
               bin_q <= shifted[WIDTH-1:0];
               cnt_q <= cnt_q + CW'(1);
            end
            COMMIT: begin
               for (int i = 0; i < DIGITS; i++) buf_q[i] <= ascii[i];
            end
            default: ;
         endcase
      end
   end

   // Registered read port; indices past the last digit read as blanks.
   always_ff @(posedge clk) begin
      if (rst)                          char_out <= 8'h20;
      else if (int'(char_idx) < DIGITS) char_out <= buf_q[char_idx];
      else                              char_out <= 8'h20;
   end

endmodule

// File: tb/tb_lcd_num_fmt.sv
// Self-checking bench for lcd_num_fmt: table of values with expected 8-character
// read-back, plus hand sequences for back-to-back starts, ignored start and mid-conversion reset.
module tb_lcd_num_fmt;

   logic        clk      = 1'b0;
   logic        rst      = 1'b1;
   logic        start    = 1'b0;
   logic [15:0] value    = '0;
   logic        busy;
   logic        done;
   logic [2:0]  char_idx = '0;
   logic [7:0]  char_out;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      logic [15:0] value;
      logic [63:0] exp;   // 8 characters, idx0 in the top byte
   } vec_t;

   vec_t vecs [10];

   lcd_num_fmt #(.WIDTH(16), .DIGITS(5)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .value    (value),
      .busy     (busy),
      .done     (done),
      .char_idx (char_idx),
      .char_out (char_out)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reads idx 0..7 and compares each against the expected string; returns at a negedge.
   task automatic read_str(input string tag, input logic [63:0] exp);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         char_idx = 3'(i);
         @(posedge clk);
         #1;
         check($sformatf("%s idx%0d", tag, i), 32'(char_out), 32'(exp[8*(7-i) +: 8]));
      end
      @(negedge clk);
   endtask

   // Called at a negedge in IDLE. lat = number of cycles after the start edge until
   // done is seen (0 on timeout); dcyc = cycle stamp of done. Returns at a negedge in IDLE.
   task automatic convert(input logic [15:0] v, output int lat, output int dcyc);
      value = v;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      lat   = 0;
      dcyc  = -1;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (done) begin
            lat  = c;
            dcyc = cyc;
            break;
         end
      end
      @(negedge clk);
   endtask

   initial begin
      int lat, d0, d1, d2, dones;

      vecs[0] = '{16'd12345, "12345   "};
      vecs[1] = '{16'd0,     "    0   "};
      vecs[2] = '{16'd7,     "    7   "};
      vecs[3] = '{16'd65535, "65535   "};
      vecs[4] = '{16'd1000,  " 1000   "};
      vecs[5] = '{16'd10,    "   10   "};
      vecs[6] = '{16'd100,   "  100   "};
      vecs[7] = '{16'd9,     "    9   "};
      vecs[8] = '{16'd40960, "40960   "};
      vecs[9] = '{16'd42,    "   42   "};

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("busy in reset", 32'(busy), 32'd0);
      check("done in reset", 32'(done), 32'd0);
      for (int i = 0; i < 8; i++) begin
         char_idx = 3'(i);
         @(posedge clk);
         #1;
         check($sformatf("char_out in reset idx%0d", i), 32'(char_out), 32'h20);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("busy after reset", 32'(busy), 32'd0);
      check("done after reset", 32'(done), 32'd0);
      read_str("buffer after reset", "        ");

      // Table-driven conversions
      for (int k = 0; k < 10; k++) begin
         convert(vecs[k].value, lat, d0);
         check($sformatf("latency value=%0d", vecs[k].value), 32'(lat), 32'd17);
         read_str($sformatf("value=%0d", vecs[k].value), vecs[k].exp);
      end

      // Back-to-back at earliest starts: dones 18 cycles apart
      convert(16'd0, lat, d0);
      check("b2b latency 0", 32'(lat), 32'd17);
      convert(16'd7, lat, d1);
      check("b2b latency 7", 32'(lat), 32'd17);
      convert(16'd65535, lat, d2);
      check("b2b latency 65535", 32'(lat), 32'd17);
      check("b2b spacing 0->7", 32'(d1 - d0), 32'd18);
      check("b2b spacing 7->65535", 32'(d2 - d1), 32'd18);
      read_str("b2b final", "65535   ");

      // Second start during CONV is ignored; old string visible until after commit
      convert(16'd42, lat, d0);
      check("latency 42 pre-ignore", 32'(lat), 32'd17);
      char_idx = 3'd4;
      value    = 16'd999;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      dones = 0;
      lat   = 0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         start = (c == 5);
         if (done) begin
            dones++;
            if (lat == 0) lat = c;
         end
         if (c <= 18) check($sformatf("old string c%0d", c), 32'(char_out), 32'h32);
         if (c == 19) check("new string after commit", 32'(char_out), 32'h39);
      end
      start = 1'b0;
      check("ignored start done count", 32'(dones), 32'd1);
      check("ignored start latency", 32'(lat), 32'd17);
      read_str("after ignored start", "  999   ");

      // Reset mid-CONV discards the conversion
      convert(16'd12345, lat, d0);
      check("latency 12345 pre-reset", 32'(lat), 32'd17);
      value = 16'd500;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      dones = 0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (c == 7) check("busy before reset", 32'(busy), 32'd1);
         rst = (c == 8);
         if (done) dones++;
      end
      rst = 1'b0;
      check("no done after mid-conv reset", 32'(dones), 32'd0);
      check("busy after mid-conv reset", 32'(busy), 32'd0);
      read_str("after mid-conv reset", "        ");
      convert(16'd500, lat, d0);
      check("latency 500 after reset", 32'(lat), 32'd17);
      read_str("value=500 after reset", "  500   ");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/lcd_num_fmt.md
# lcd_num_fmt

Sequential binary-to-ASCII formatter placed directly upstream of the character LCD driver. Accepts an unsigned binary measurement (e.g. velocity), converts it to decimal with a shift-add-3 (double-dabble) engine, applies leading-zero blanking, and holds the resulting ASCII string in a register buffer. The LCD driver reads one character per print state through a registered index/read port.

## Interface

Parameters:
- WIDTH, 16, bit width of the binary input value.
- DIGITS, 5, number of decimal characters produced; must satisfy 10^DIGITS > 2^WIDTH - 1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request conversion of value; sampled only in IDLE.
- value  in  WIDTH  unsigned binary input; latched on accepted start.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse when the new string is committed to the buffer.
- char_idx  in  3  character index; 0 = most significant digit.
- char_out  out  8  ASCII character at char_idx, registered.

## Operation

- FSM states: IDLE, CONV, COMMIT.
- IDLE: busy=0. If start=1, latch value into a shift register, clear the BCD register (4*DIGITS bits), clear the iteration counter, and go to CONV.
- CONV: busy=1. Each cycle: for every BCD nibble >= 5, add 3; then shift {bcd, bin} left by one. Both steps complete in one cycle. The counter increments. After exactly WIDTH iterations, go to COMMIT.
- COMMIT: busy=1, done=1. Build the ASCII buffer:
  - Each digit maps to 0x30 + nibble.
  - Blanking: every digit more significant than the first nonzero digit becomes 0x20.
  - The least significant digit is never blanked, so value 0 gives "    0".
  - The buffer is written this cycle. Next state is IDLE.
- start outside IDLE is ignored and is not queued.
- Buffer is double-buffered: it changes only in COMMIT, so the LCD driver always reads a complete, consistent string.
- Read port: char_out <= buffer[char_idx] on every clock edge. If char_idx >= DIGITS, char_out <= 0x20.
- Reset (any state, including mid-CONV): FSM to IDLE; counter, BCD and binary shift registers cleared; buffer filled with 0x20. The in-flight conversion is discarded and done is not produced.

## Timing

- Reset values: busy=0, done=0, char_out=0x20, all buffer entries 0x20.
- start is accepted at edge N (in IDLE).
  - busy rises after edge N.
  - CONV occupies cycles N+1 .. N+WIDTH.
  - COMMIT occupies cycle N+WIDTH+1: done=1, and the buffer is written at the end of that cycle.
  - busy falls after edge N+WIDTH+1.
- Total latency from start to done is WIDTH+1 cycles (17 with defaults).
- Earliest next accepted start is at edge N+WIDTH+2: one IDLE cycle is required between conversions.
- Read latency is 1 cycle.
  - A read issued on the cycle after done returns the new string.
  - A read issued during COMMIT returns the old string.
- Counter width is clog2(WIDTH+1).
- Per-nibble add-3 uses 4-bit arithmetic. The carry into the next nibble comes from the shift only, never from the add.
- done is never asserted together with rst.

## Test plan

- Reset, no start -> busy=0, done=0, char_out=0x20 for char_idx 0..7.
- start with value=12345 -> done exactly 17 cycles after start. Reads of idx 0..4 return 0x31,0x32,0x33,0x34,0x35; idx 5..7 return 0x20.
- value=0, then value=7, then value=65535 back-to-back at the earliest allowed starts -> "    0", "    7", "65535". Each done is spaced 18 cycles apart.
- value=1000 -> " 1000": idx0=0x20, idx1=0x31, idx2..4=0x30. Internal zeros are not blanked.
- value=42 completed; then start with 999 and pulse start again at cycle 5 of CONV -> second pulse ignored, exactly one done. Buffer reads "   42" until done, then "  999".
- value=12345 completed; then start with 500 and assert rst at cycle 8 of CONV -> no done. busy=0 and all reads 0x20 after reset. A new start with 500 then yields "  500".
